// File: rtl/multi_clock_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_pkg
// Description : Shared constants and helpers for the multi-channel divider.
// Revision    : 1.0  initial release
// ============================================================================
package clkdiv_pkg;

    localparam int MAX_CH   = 8;
    localparam int CH_IDX_W = 3;

    // A zero half-period would never wrap; treat it as the fastest legal rate.
    function automatic logic [31:0] clamp_half(input logic [31:0] val);
        return (val == 32'd0) ? 32'd1 : val;
    endfunction

endpackage : clkdiv_pkg
`default_nettype wire

// File: rtl/multi_clock_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_clock_divider_if
// Description : Control/load/output bundle of the multi-channel divider.
// Revision    : 1.0  initial release
// ============================================================================
interface multi_clock_divider_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 26
);
    logic [NUM_CH-1:0]                en;
    logic                             sync;
    logic                             load;
    logic [clkdiv_pkg::CH_IDX_W-1:0]  load_ch;
    logic [CNT_W-1:0]                 load_val;
    logic [NUM_CH-1:0]                clk_out;
    logic [NUM_CH-1:0]                tick;

    modport master (
        output en, sync, load, load_ch, load_val,
        input  clk_out, tick
    );

    modport slave (
        input  en, sync, load, load_ch, load_val,
        output clk_out, tick
    );
endinterface : multi_clock_divider_if
`default_nettype wire

// File: rtl/multi_clock_divider_channel.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_channel
// Description : One divider channel: counter, half-period registers, toggle
//               and tick. DIV_IMMEDIATE_LOAD_EN selects immediate reload
//               instead of the deferred shadow reload at the next toggle.
// Revision    : 1.0  initial release
// ============================================================================
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int               CNT_W      = 26,
    parameter logic [CNT_W-1:0] HALF_RESET = CNT_W'(1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_en,
    input  wire logic             i_sync,
    input  wire logic             i_load,
    input  wire logic [CNT_W-1:0] i_load_val,
    output logic                  o_clk_out,
    output logic                  o_tick
);

    localparam logic [CNT_W-1:0] c_half_reset = CNT_W'(clamp_half(32'(HALF_RESET)));

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_active;
    logic             r_clk_out;
    logic             r_tick;
    logic [CNT_W-1:0] w_load_half;
    logic             w_wrap;
    logic             w_run;

    assign w_load_half = CNT_W'(clamp_half(32'(i_load_val)));
    // >= lets a count already past a freshly shortened period wrap at once.
    assign w_wrap      = (r_cnt >= (r_active - CNT_W'(1)));

`ifdef DIV_IMMEDIATE_LOAD_EN
    // A load restarts the period and holds the output level for that cycle.
    assign w_run = i_en && !i_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_active  <= c_half_reset;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            if (i_sync) begin
                r_cnt     <= '0;
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
            end else if (w_run) begin
                if (w_wrap) begin
                    r_clk_out <= ~r_clk_out;
                    r_cnt     <= '0;
                    r_tick    <= 1'b1;
                end else begin
                    r_cnt  <= r_cnt + CNT_W'(1);
                    r_tick <= 1'b0;
                end
            end else begin
                r_tick <= 1'b0;
            end
            if (i_load) begin
                r_active <= w_load_half;
                r_cnt    <= '0;
            end
        end
    end
`else
    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;

    assign w_run = i_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_active  <= c_half_reset;
            r_shadow  <= c_half_reset;
            r_pending <= 1'b0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            if (i_sync) begin
                r_cnt     <= '0;
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
            end else if (w_run) begin
                if (w_wrap) begin
                    r_clk_out <= ~r_clk_out;
                    r_cnt     <= '0;
                    r_tick    <= 1'b1;
                    if (r_pending) begin
                        r_active  <= r_shadow;
                        r_pending <= 1'b0;
                    end
                end else begin
                    r_cnt  <= r_cnt + CNT_W'(1);
                    r_tick <= 1'b0;
                end
            end else begin
                r_tick <= 1'b0;
            end
            // Placed last so a load colliding with a toggle stays pending.
            if (i_load) begin
                r_shadow  <= w_load_half;
                r_pending <= 1'b1;
            end
        end
    end
`endif

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;

endmodule : clkdiv_channel
`default_nettype wire

// File: rtl/multi_clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : multi_clock_divider
// Description : NUM_CH programmable clock-enable dividers with shared sync and
//               load decode. Honours DIV_IMMEDIATE_LOAD_EN in each channel.
// Revision    : 1.0  initial release
// ============================================================================
module multi_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int                      NUM_CH       = 2,
    parameter int                      CNT_W        = 26,
    parameter logic [NUM_CH*CNT_W-1:0] HALF_DEFAULT = {26'd25000, 26'd50000000}
) (
    input  wire logic            clk,
    input  wire logic            ar,
    multi_clock_divider_if.slave bus
);

    logic [NUM_CH-1:0] w_clk_out;
    logic [NUM_CH-1:0] w_tick;
    logic [NUM_CH-1:0] w_load_sel;

    // Full-width index compare: out-of-range channels match nothing.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign w_load_sel[gi] = bus.load && (bus.load_ch == CH_IDX_W'(gi));

        clkdiv_channel #(
            .CNT_W      (CNT_W),
            .HALF_RESET (HALF_DEFAULT[gi*CNT_W +: CNT_W])
        ) u_ch (
            .clk        (clk),
            .rst        (ar),
            .i_en       (bus.en[gi]),
            .i_sync     (bus.sync),
            .i_load     (w_load_sel[gi]),
            .i_load_val (bus.load_val),
            .o_clk_out  (w_clk_out[gi]),
            .o_tick     (w_tick[gi])
        );
    end

    assign bus.clk_out = w_clk_out;
    assign bus.tick    = w_tick;

endmodule : multi_clock_divider
`default_nettype wire

// File: tb/tb_multi_clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_clock_divider
// Description : Directed self-checking bench, 2 channels, 4-bit counters,
//               reset half-periods ch0=3 and ch1=5.
// Revision    : 1.0  initial release
// ============================================================================
module tb_multi_clock_divider;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    logic ar  = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    multi_clock_divider_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    multi_clock_divider #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .HALF_DEFAULT (8'h53)
    ) dut (
        .clk (clk),
        .ar  (ar),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.en       = '0;
        bus.sync     = 1'b0;
        bus.load     = 1'b0;
        bus.load_ch  = '0;
        bus.load_val = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        ar = 1'b1;
        step();
        ar = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        idle_inputs();
        ar = 1'b1;
        #3;
        got = {bus.tick, bus.clk_out};
        checks++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000", got);
        end
        step();
        ar = 1'b0;
        bus.en = 2'b11;
        step(); step(); step();
        got = {bus.tick, bus.clk_out};
        checks++;
        if (got !== 4'b0101) begin
            errors++;
            $display("FAIL first_toggle: got %b expected 0101", got);
        end
        #2 ar = 1'b1;
        #1;
        got = {bus.tick, bus.clk_out};
        checks++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: got %b expected 0000", got);
        end
        step();
        ar = 1'b0;
    endtask

    task automatic test_toggle();
        logic [3:0] exp, got;
        apply_reset();
        bus.en = 2'b11;
        for (int k = 1; k <= 30; k++) begin
            step();
            exp = {(k % 5) == 0, (k % 3) == 0, ((k / 5) % 2) == 1, ((k / 3) % 2) == 1};
            got = {bus.tick, bus.clk_out};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL toggle edge %0d: got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_deferred_load();
        logic [11:0] et0, eo0, et1, eo1;
        logic [3:0]  exp, got;
        et0 = 12'b001001010101;
        eo0 = 12'b001110011001;
        et1 = 12'b000010000100;
        eo1 = 12'b000011111000;
        apply_reset();
        bus.en       = 2'b11;
        bus.load_ch  = 3'd0;
        bus.load_val = 4'd2;
        for (int k = 0; k < 12; k++) begin
            bus.load = (k == 3);
            step();
            exp = {et1[11-k], et0[11-k], eo1[11-k], eo0[11-k]};
            got = {bus.tick, bus.clk_out};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL load_ch0 edge %0d: got %b expected %b", k + 1, got, exp);
            end
        end
        bus.load = 1'b0;
    endtask

    task automatic test_zero_load();
        logic [7:0] et0, eo0, et1, eo1;
        logic [3:0] exp, got;
        et0 = 8'b00100100;
        eo0 = 8'b00111000;
`ifdef DIV_IMMEDIATE_LOAD_EN
        et1 = 8'b01111111;
        eo1 = 8'b01010101;
`else
        et1 = 8'b00001111;
        eo1 = 8'b00001010;
`endif
        apply_reset();
        bus.en       = 2'b11;
        bus.load_ch  = 3'd1;
        bus.load_val = 4'd0;
        for (int k = 0; k < 8; k++) begin
            bus.load = (k == 0);
            step();
            exp = {et1[7-k], et0[7-k], eo1[7-k], eo0[7-k]};
            got = {bus.tick, bus.clk_out};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL zero_load edge %0d: got %b expected %b", k + 1, got, exp);
            end
        end
        bus.load = 1'b0;
    endtask

    task automatic test_enable();
        logic [13:0] et0, eo0, et1, eo1;
        logic [3:0]  exp, got;
        et0 = 14'b00000000010010;
        eo0 = 14'b00000000011100;
        et1 = 14'b00001000010000;
        eo1 = 14'b00001111100000;
        apply_reset();
        for (int k = 0; k < 14; k++) begin
            bus.en = (k >= 2 && k <= 8) ? 2'b10 : 2'b11;
            step();
            exp = {et1[13-k], et0[13-k], eo1[13-k], eo0[13-k]};
            got = {bus.tick, bus.clk_out};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL enable_hold edge %0d: got %b expected %b", k + 1, got, exp);
            end
        end
    endtask

    task automatic test_sync();
        logic [11:0] et0, eo0, et1, eo1;
        logic [3:0]  exp, got;
        et0 = 12'b001000001001;
        eo0 = 12'b001110001110;
        et1 = 12'b000010000010;
        eo1 = 12'b000010000011;
        apply_reset();
        bus.en = 2'b11;
        for (int k = 0; k < 12; k++) begin
            bus.sync = (k == 5);
            step();
            exp = {et1[11-k], et0[11-k], eo1[11-k], eo0[11-k]};
            got = {bus.tick, bus.clk_out};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL sync edge %0d: got %b expected %b", k + 1, got, exp);
            end
        end
        bus.sync = 1'b0;
    endtask

    task automatic test_invalid_load_and_reset();
        logic [9:0] et0, eo0, et1, eo1;
        logic [5:0] ft0, fo0, ft1, fo1;
        logic [3:0] exp, got;
        et0 = 10'b0010010010;
        eo0 = 10'b0011100011;
        et1 = 10'b0000100001;
        eo1 = 10'b0000111110;
        ft0 = 6'b001001;
        fo0 = 6'b001110;
        ft1 = 6'b000010;
        fo1 = 6'b000011;
        apply_reset();
        bus.en       = 2'b11;
        bus.load_ch  = 3'd5;
        bus.load_val = 4'd1;
        for (int k = 0; k < 10; k++) begin
            bus.load = (k == 0);
            step();
            exp = {et1[9-k], et0[9-k], eo1[9-k], eo0[9-k]};
            got = {bus.tick, bus.clk_out};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL bad_ch_load edge %0d: got %b expected %b", k + 1, got, exp);
            end
        end
        // Leave a valid ch0 load outstanding, then reset mid-count.
        bus.load_ch = 3'd0;
        bus.load    = 1'b1;
        step();
        bus.load = 1'b0;
        #2 ar = 1'b1;
        #1;
        got = {bus.tick, bus.clk_out};
        checks++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL midrun_reset: got %b expected 0000", got);
        end
        step();
        ar     = 1'b0;
        bus.en = 2'b11;
        for (int k = 0; k < 6; k++) begin
            step();
            exp = {ft1[5-k], ft0[5-k], fo1[5-k], fo0[5-k]};
            got = {bus.tick, bus.clk_out};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL post_reset edge %0d: got %b expected %b", k + 1, got, exp);
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_toggle();
        test_deferred_load();
        test_zero_load();
        test_enable();
        test_sync();
        test_invalid_load_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_multi_clock_divider
`default_nettype wire
